alu_arbiter: RTL and testbench

- Shares one ALU_16bit instance between two requesters.
- Accepts one operation at a time over valid/ready, chooses the requester round-robin, drives the ALU operands and opcode, and waits the ALU latency.
- Captures the 32-bit result and returns it to the granted requester over a valid/ready response channel.
- Sits between requester logic and the ALU_16bit ports a/b/sel/out/selected_op.

---
 rtl/alu_arb_pkg.sv | 22 ++
 rtl/alu_arbiter_rr_arb2.sv | 23 ++
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
//   state_t : arbiter FSM states
//   OP_*    : ALU opcode encodings carried on req_sel / alu_sel
//   OPND_W  : operand width, RES_W : ALU result width, N_REQ : requester count
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  localparam int OPND_W = 16;
  localparam int RES_W  = 32;
  localparam int N_REQ  = 2;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way combinational grant selector.
// Ports:
//   req        : request vector, bit i = requester i
//   last_grant : requester that won the previous arbitration
//   fixed_pri  : 1 = requester 0 always wins a tie, 0 = alternate on ties
//   grant      : index of the winner (0 when nobody requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_pri,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = fixed_pri ? 1'b0 : ~last_grant;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU_16bit between two requesters. One operation in flight:
// arbitrate, drive the ALU, wait ALU_LATENCY, capture the result and hand
// it back on the owner's response channel.
// Build option: define ALU_ARB_FIXED_PRIORITY_EN to make requester 0 win
// every tie (no last-grant register); otherwise ties alternate.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready/req_a/req_b/req_sel : per-requester request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_err    : per-requester response channel
//   alu_a/alu_b/alu_sel/alu_reset           : to the ALU
//   alu_out/alu_selected_op                 : from the ALU
//   busy                                    : FSM not in IDLE
//
// state | meaning
// IDLE  | arbitrating, req_ready offered to the winner
// EXEC  | operands held on the ALU, latency counter running down
// RESP  | result captured, rsp_valid held until owner's rsp_ready
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OPND_W-1:0] req_a,
  input  logic [N_REQ*OPND_W-1:0] req_b,
  input  logic [2*N_REQ-1:0]      req_sel,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [RES_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic [OPND_W-1:0]       alu_a,
  output logic [OPND_W-1:0]       alu_b,
  output logic [1:0]              alu_sel,
  output logic                    alu_reset,
  input  logic [RES_W-1:0]        alu_out,
  input  logic [1:0]              alu_selected_op,
  output logic                    busy
);

  localparam logic [2:0] LAT_LD = 3'(ALU_LATENCY);

  state_t     state;
  logic       owner;
  logic [2:0] cnt;
  logic       grant;
  logic       rr_last;
  logic       accept;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  localparam logic FIXED_PRI = 1'b1;
  assign rr_last = 1'b0;
`else
  localparam logic FIXED_PRI = 1'b0;
  logic last_grant;
  assign rr_last = last_grant;
`endif

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (rr_last),
    .fixed_pri  (FIXED_PRI),
    .grant      (grant)
  );

  // Gated by reset so nothing is offered while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && reset && req_valid != '0) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept    = |(req_valid & req_ready);
  assign alu_reset = ~reset;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= req_a[{grant, 4'b0000} +: OPND_W];
            alu_b   <= req_b[{grant, 4'b0000} +: OPND_W];
            alu_sel <= req_sel[{grant, 1'b0} +: 2];
            owner   <= grant;
            cnt     <= LAT_LD;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // Terminal count: the ALU output has settled for this operand set.
          if (cnt == 3'd0) begin
            rsp_data  <= alu_out;
            rsp_err   <= (alu_selected_op != alu_sel);
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ALU_ARB_FIXED_PRIORITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && accept) begin
      last_grant <= grant;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int L = 1;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_sel = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_sel;
  logic        alu_reset;
  logic [31:0] alu_out;
  logic [1:0]  alu_selected_op;
  logic        busy;
  logic        err_inj = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.ALU_LATENCY(L)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_a           (req_a),
    .req_b           (req_b),
    .req_sel         (req_sel),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_sel         (alu_sel),
    .alu_reset       (alu_reset),
    .alu_out         (alu_out),
    .alu_selected_op (alu_selected_op),
    .busy            (busy)
  );

  function automatic logic [31:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] s);
    logic [31:0] xa;
    logic [31:0] xb;
    xa = {16'd0, a};
    xb = {16'd0, b};
    case (s)
      2'b00:   return xa + xb;
      2'b01:   return xa - xb;
      2'b10:   return xa * xb;
      default: return xa >> b[3:0];
    endcase
  endfunction

  // ALU stand-in: L register stages from operands to result.
  logic [31:0] pipe_out [L];
  logic [1:0]  pipe_op  [L];
  always @(posedge clk or posedge alu_reset) begin
    if (alu_reset) begin
      for (int i = 0; i < L; i++) begin
        pipe_out[i] <= '0;
        pipe_op[i]  <= '0;
      end
    end else begin
      pipe_out[0] <= alu_f(alu_a, alu_b, alu_sel);
      pipe_op[0]  <= alu_sel;
      for (int i = 1; i < L; i++) begin
        pipe_out[i] <= pipe_out[i-1];
        pipe_op[i]  <= pipe_op[i-1];
      end
    end
  end
  assign alu_out         = pipe_out[L-1];
  assign alu_selected_op = pipe_op[L-1] ^ {1'b0, err_inj};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one op in flight, tracked by its age in cycles.
  bit          m_busy = 0;
  int          m_age = 0;
  int          m_owner = 0;
  int          m_last = 1;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic [1:0]  m_sel = '0;
  logic [31:0] m_rsp_data = '0;
  logic        m_rsp_err = 1'b0;
  int          m_g;
  logic [1:0]  m_exp_ready;
  logic [1:0]  m_exp_rv;

  always @(negedge clk) begin
    #3;
    if (!reset) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_alu_sel", 32'(alu_sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_reset", 32'(alu_reset), 32'd1);
      m_busy = 0; m_age = 0; m_owner = 0; m_last = 1;
      m_a = '0; m_b = '0; m_sel = '0; m_rsp_data = '0; m_rsp_err = 1'b0;
    end else begin
      if (req_valid == 2'b11) m_g = FIXED ? 0 : (m_last == 1 ? 0 : 1);
      else                    m_g = (req_valid == 2'b10) ? 1 : 0;
      m_exp_ready = (!m_busy && req_valid != 2'b00) ? 2'(2'b01 << m_g) : 2'b00;
      m_exp_rv    = (m_busy && m_age >= L + 2) ? 2'(2'b01 << m_owner) : 2'b00;
      chk("m_req_ready", 32'(req_ready), 32'(m_exp_ready));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_exp_rv));
      chk("m_rsp_data", rsp_data, m_rsp_data);
      chk("m_rsp_err", 32'(rsp_err), 32'(m_rsp_err));
      chk("m_alu_a", 32'(alu_a), 32'(m_a));
      chk("m_alu_b", 32'(alu_b), 32'(m_b));
      chk("m_alu_sel", 32'(alu_sel), 32'(m_sel));
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_alu_reset", 32'(alu_reset), 32'd0);
      if (!m_busy) begin
        if (m_exp_ready != 2'b00) begin
          m_busy  = 1;
          m_age   = 1;
          m_owner = m_g;
          m_last  = m_g;
          m_a     = req_a[16*m_g +: 16];
          m_b     = req_b[16*m_g +: 16];
          m_sel   = req_sel[2*m_g +: 2];
        end
      end else if (m_age < L + 1) begin
        m_age++;
      end else if (m_age == L + 1) begin
        m_rsp_data = alu_f(m_a, m_b, m_sel);
        m_rsp_err  = err_inj;
        m_age++;
      end else if (rsp_ready[m_owner]) begin
        m_busy = 0;
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = '0;
  endtask

  task automatic rand_inputs();
    req_valid = 2'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    req_sel   = 4'($urandom);
    rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
    err_inj   = ($urandom_range(0, 7) == 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      rand_inputs();
      #1;
      chk("rst_lit_busy", 32'(busy), 32'd0);
      chk("rst_lit_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_lit_alu_reset", 32'(alu_reset), 32'd1);
    end
    next_cycle();
    reset = 1'b1;
    err_inj = 1'b0;
    idle_inputs();
    #1;
    chk("rel_alu_reset", 32'(alu_reset), 32'd0);
  endtask

  task automatic wait_rsp(input int who, output int n, output logic ok);
    ok = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      if (rsp_valid[who]) begin
        ok = 1'b1;
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_ready(output int who, output logic ok);
    ok = 1'b0;
    who = -1;
    for (int k = 0; k < 20; k++) begin
      if (req_ready != 2'b00) begin
        ok = 1'b1;
        who = req_ready[1] ? 1 : 0;
        break;
      end
      next_cycle();
    end
  endtask

  task automatic single_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s,
                           input logic [31:0] exp_d, input logic exp_e);
    int   n;
    logic ok;
    next_cycle();
    req_valid = 2'b01;
    req_a = {16'd0, a};
    req_b = {16'd0, b};
    req_sel = {2'b00, s};
    rsp_ready = 2'b11;
    #1;
    chk("op_req_ready", 32'(req_ready), 32'd1);
    wait_rsp(0, n, ok);
    chk("op_rsp_seen", 32'(ok), 32'd1);
    chk("op_latency", 32'(n), 32'd3);
    chk("op_rsp_data", rsp_data, exp_d);
    chk("op_rsp_err", 32'(rsp_err), 32'(exp_e));
    req_valid = 2'b00;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          n;
    int          who;
    logic        ok;
    int          exp_g [4];
    logic [31:0] exp_d [4];

    #1;
    do_reset();

    single_op(16'd12, 16'd2, 2'b00, 32'd14, 1'b0);

    // Contention from a fresh reset so requester 0 wins the first tie.
    do_reset();
    exp_g[0] = 0; exp_d[0] = 32'd16;
    if (FIXED) begin
      exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
      exp_d[1] = 32'd16; exp_d[2] = 32'd16; exp_d[3] = 32'd16;
    end else begin
      exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
      exp_d[1] = 32'd64; exp_d[2] = 32'd16; exp_d[3] = 32'd64;
    end
    req_valid = 2'b11;
    req_a     = {16'd8, 16'd32};
    req_b     = {16'd8, 16'd16};
    req_sel   = {2'b10, 2'b01};
    rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_ready(who, ok);
      chk("cont_ready_seen", 32'(ok), 32'd1);
      chk("cont_grant", 32'(who), 32'(exp_g[k]));
      wait_rsp(who < 0 ? 0 : who, n, ok);
      chk("cont_rsp_seen", 32'(ok), 32'd1);
      chk("cont_rsp_data", rsp_data, exp_d[k]);
    end
    req_valid = 2'b00;

    // Backpressure on requester 1; requester 0 waits behind it.
    next_cycle();
    req_valid = 2'b10;
    req_a     = {16'h0478, 16'd0};
    req_b     = {16'd4, 16'd0};
    req_sel   = {2'b11, 2'b00};
    rsp_ready = 2'b00;
    #1;
    chk("bp_req_ready", 32'(req_ready), 32'd2);
    wait_rsp(1, n, ok);
    chk("bp_rsp_seen", 32'(ok), 32'd1);
    req_valid = 2'b11;
    rsp_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd2);
      chk("bp_rsp_data", rsp_data, 32'h47);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_no_accept", 32'(req_ready), 32'd0);
    end
    rsp_ready = 2'b10;
    next_cycle();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    req_valid = 2'b00;

    // Reset while the operation is in EXEC: its response must never appear.
    next_cycle();
    req_valid = 2'b01;
    req_a = {16'd0, 16'd12};
    req_b = {16'd0, 16'd2};
    req_sel = 4'b0000;
    rsp_ready = 2'b11;
    next_cycle();
    req_valid = 2'b00;
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    single_op(16'd12, 16'd2, 2'b00, 32'd14, 1'b0);

    // Opcode echo mismatch at capture.
    err_inj = 1'b1;
    single_op(16'd5, 16'd3, 2'b10, 32'd15, 1'b1);
    err_inj = 1'b0;

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      next_cycle();
      rand_inputs();
      reset = ($urandom_range(0, 59) != 0);
    end
    next_cycle();
    reset = 1'b1;
    idle_inputs();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
